// File: rtl/axis_mux_user_sq_pkg.sv
// axis_mux_user_sq_pkg
//   Shared types and sizing for the send-queue stream multiplexer:
//   request descriptor layout, data-path widths and a clog2 helper
//   that never returns 0 (so a single-entry select still has a 1-bit index).
package axis_mux_user_sq_pkg;

  localparam int AXI_DATA_BITS   = 512;
  localparam int PID_BITS        = 6;
  localparam int OPCODE_BITS     = 5;
  localparam int DEST_FIELD_BITS = 4;
  localparam int LEN_BITS        = 28;
  localparam int BEAT_LOG_BITS   = $clog2(AXI_DATA_BITS / 8);
  localparam int BLEN_BITS       = LEN_BITS - BEAT_LOG_BITS;

  typedef struct packed {
    logic [OPCODE_BITS-1:0]     opcode;
    logic [PID_BITS-1:0]        pid;
    logic [DEST_FIELD_BITS-1:0] dest;
    logic [LEN_BITS-1:0]        len;
  } req_t;

  localparam int REQ_BITS = $bits(req_t);

  function automatic int clog2s(input int v);
    if (v < 2) return 1;
    return $clog2(v);
  endfunction

endpackage

// File: rtl/axis_mux_user_sq_meta_queue.sv
// axis_mux_user_sq_meta_queue
//   One-entry valid/ready register used to forward accepted requests.
//   A full entry can be replaced in the same cycle it is popped.
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   s_valid/s_ready/s_data push side
//   m_valid/m_ready/m_data pop side
module axis_mux_user_sq_meta_queue #(
  parameter int DATA_BITS = 1
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_BITS-1:0] m_data
);

  logic                 full_C;
  logic [DATA_BITS-1:0] data_C;

  assign s_ready = ~full_C | m_ready;
  assign m_valid = full_C;
  assign m_data  = data_C;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      full_C <= 1'b0;
      data_C <= '0;
    end else if (s_valid && s_ready) begin
      full_C <= 1'b1;
      data_C <= s_data;
    end else if (m_ready) begin
      full_C <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_mux_user_sq.sv
// axis_mux_user_sq
//   Merges N_SRCS user send streams into one outbound stream, one request
//   at a time, in request order. Each accepted request is forwarded through
//   a one-entry meta register and gates exactly ceil(len/beat) beats from
//   the source selected by its dest field.
// Ports:
//   aclk, aresetn                  clock, async active-low reset
//   s_sq_valid/ready/data          incoming request (req_t, flattened)
//   m_sq_valid/ready/data          forwarded request, registered
//   s_axis_send_*                  per-source data, flattened by index
//   m_axis_*                       merged outbound data
// Build option:
//   AXIS_MUX_SQ_LAST_GEN_EN  when defined, tlast is generated from the beat
//                            count; otherwise source tlast is passed through.
//
// state   | meaning
// ST_IDLE | no transfer active, data path closed
// ST_MUX  | forwarding beats from source dest_C until cnt_C reaches 0
module axis_mux_user_sq import axis_mux_user_sq_pkg::*; #(
  parameter int N_SRCS = 1
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic                             s_sq_valid,
  output logic                             s_sq_ready,
  input  logic [REQ_BITS-1:0]              s_sq_data,
  output logic                             m_sq_valid,
  input  logic                             m_sq_ready,
  output logic [REQ_BITS-1:0]              m_sq_data,
  input  logic [N_SRCS-1:0]                s_axis_send_tvalid,
  output logic [N_SRCS-1:0]                s_axis_send_tready,
  input  logic [N_SRCS*AXI_DATA_BITS-1:0]  s_axis_send_tdata,
  input  logic [N_SRCS*AXI_DATA_BITS/8-1:0] s_axis_send_tkeep,
  input  logic [N_SRCS-1:0]                s_axis_send_tlast,
  input  logic [N_SRCS*PID_BITS-1:0]       s_axis_send_tid,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [AXI_DATA_BITS-1:0]         m_axis_tdata,
  output logic [AXI_DATA_BITS/8-1:0]       m_axis_tkeep,
  output logic                             m_axis_tlast
);

  localparam int DEST_BITS = clog2s(N_SRCS);

  typedef enum logic {ST_IDLE, ST_MUX} state_t;

  state_t                state_C, state_N;
  logic [BLEN_BITS-1:0]  cnt_C, cnt_N;
  logic [DEST_BITS-1:0]  dest_C, dest_N;
  logic [PID_BITS-1:0]   pid_C, pid_N;

  req_t                  req;
  logic                  dest_ok;
  logic [LEN_BITS-1:0]   len_m1;
  logic [BLEN_BITS-1:0]  cnt_load;
  logic                  q_ready;
  logic                  acc;
  logic                  hs;
  logic                  tr_done;

  logic                        sel_tvalid;
  logic [AXI_DATA_BITS-1:0]    sel_tdata;
  logic [AXI_DATA_BITS/8-1:0]  sel_tkeep;
  logic                        sel_tlast;

  assign req      = req_t'(s_sq_data);
  assign dest_ok  = 32'(req.dest) < N_SRCS;
  assign len_m1   = req.len - LEN_BITS'(1);
  // A zero length still moves one beat.
  assign cnt_load = (req.len == '0) ? '0 : BLEN_BITS'(len_m1 >> BEAT_LOG_BITS);

  assign hs      = m_axis_tvalid & m_axis_tready;
  assign tr_done = hs & (cnt_C == '0);
  // Out-of-range requests are consumed here but never pushed or muxed.
  assign acc        = s_sq_valid & q_ready & ((state_C == ST_IDLE) | tr_done);
  assign s_sq_ready = acc;

  axis_mux_user_sq_meta_queue #(
    .DATA_BITS (REQ_BITS)
  ) u_meta_queue (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_valid (acc & dest_ok),
    .s_ready (q_ready),
    .s_data  (s_sq_data),
    .m_valid (m_sq_valid),
    .m_ready (m_sq_ready),
    .m_data  (m_sq_data)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_C <= ST_IDLE;
      cnt_C   <= '0;
      dest_C  <= '0;
      pid_C   <= '0;
    end else begin
      state_C <= state_N;
      cnt_C   <= cnt_N;
      dest_C  <= dest_N;
      pid_C   <= pid_N;
    end
  end

  always_comb begin
    state_N = state_C;
    cnt_N   = cnt_C;
    dest_N  = dest_C;
    pid_N   = pid_C;
    if (state_C == ST_MUX && hs) begin
      if (cnt_C != '0) cnt_N = cnt_C - BLEN_BITS'(1);
      else             state_N = ST_IDLE;
    end
    // A new request loaded on the tr_done cycle overrides the IDLE return.
    if (acc && dest_ok) begin
      state_N = ST_MUX;
      cnt_N   = cnt_load;
      dest_N  = req.dest[DEST_BITS-1:0];
      pid_N   = req.pid;
    end
  end

  always_comb begin
    sel_tvalid         = 1'b0;
    sel_tdata          = '0;
    sel_tkeep          = '0;
    sel_tlast          = 1'b0;
    s_axis_send_tready = '0;
    for (int i = 0; i < N_SRCS; i++) begin
      if (32'(dest_C) == i) begin
        sel_tvalid            = s_axis_send_tvalid[i];
        sel_tdata             = s_axis_send_tdata[i*AXI_DATA_BITS +: AXI_DATA_BITS];
        sel_tkeep             = s_axis_send_tkeep[i*(AXI_DATA_BITS/8) +: AXI_DATA_BITS/8];
        sel_tlast             = s_axis_send_tlast[i];
        s_axis_send_tready[i] = (state_C == ST_MUX) & m_axis_tready;
      end
    end
  end

  assign m_axis_tvalid = (state_C == ST_MUX) & sel_tvalid;
  assign m_axis_tdata  = sel_tdata;
  assign m_axis_tkeep  = sel_tkeep;

  // Source tid and the latched pid are carried for bookkeeping only.
`ifdef AXIS_MUX_SQ_LAST_GEN_EN
  assign m_axis_tlast = (state_C == ST_MUX) & (cnt_C == '0);
  logic unused_sig;
  assign unused_sig = ^{pid_C, req.opcode, s_axis_send_tid, sel_tlast};
`else
  assign m_axis_tlast = (state_C == ST_MUX) & sel_tlast;
  logic unused_sig;
  assign unused_sig = ^{pid_C, req.opcode, s_axis_send_tid};
`endif

endmodule

// File: tb/tb_axis_mux_user_sq.sv
module tb_axis_mux_user_sq;
  import axis_mux_user_sq_pkg::*;

  localparam int N  = 4;
  localparam int DB = AXI_DATA_BITS;

  logic                  aclk;
  logic                  aresetn;
  logic                  s_sq_valid;
  logic                  s_sq_ready;
  logic [REQ_BITS-1:0]   s_sq_data;
  logic                  m_sq_valid;
  logic                  m_sq_ready;
  logic [REQ_BITS-1:0]   m_sq_data;
  logic [N-1:0]          s_axis_send_tvalid;
  logic [N-1:0]          s_axis_send_tready;
  logic [N*DB-1:0]       s_axis_send_tdata;
  logic [N*DB/8-1:0]     s_axis_send_tkeep;
  logic [N-1:0]          s_axis_send_tlast;
  logic [N*PID_BITS-1:0] s_axis_send_tid;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [DB-1:0]         m_axis_tdata;
  logic [DB/8-1:0]       m_axis_tkeep;
  logic                  m_axis_tlast;

  int tests = 0;
  int fails = 0;

  axis_mux_user_sq #(.N_SRCS(N)) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .s_sq_valid         (s_sq_valid),
    .s_sq_ready         (s_sq_ready),
    .s_sq_data          (s_sq_data),
    .m_sq_valid         (m_sq_valid),
    .m_sq_ready         (m_sq_ready),
    .m_sq_data          (m_sq_data),
    .s_axis_send_tvalid (s_axis_send_tvalid),
    .s_axis_send_tready (s_axis_send_tready),
    .s_axis_send_tdata  (s_axis_send_tdata),
    .s_axis_send_tkeep  (s_axis_send_tkeep),
    .s_axis_send_tlast  (s_axis_send_tlast),
    .s_axis_send_tid    (s_axis_send_tid),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tkeep       (m_axis_tkeep),
    .m_axis_tlast       (m_axis_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DB-1:0] src_word(input int i);
    return {16{32'hC0DE_0000 + 32'(i)}};
  endfunction

  function automatic logic [REQ_BITS-1:0] mk_req(input int op, input int pid, input int dest, input int len);
    req_t r;
    r.opcode = OPCODE_BITS'(op);
    r.pid    = PID_BITS'(pid);
    r.dest   = DEST_FIELD_BITS'(dest);
    r.len    = LEN_BITS'(len);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Presents a request and holds it until accepted (bounded), then drops valid.
  task automatic send_req(input logic [REQ_BITS-1:0] r, input string tag);
    int waited;
    waited = 0;
    s_sq_valid = 1'b1;
    s_sq_data  = r;
    #1;
    while (!s_sq_ready && waited < 20) begin
      step();
      waited++;
    end
    chk(tag, s_sq_ready, 1);
    step();
    s_sq_valid = 1'b0;
    #1;
  endtask

  // Counts handshaked beats until the mux closes; checks data and tready mask per beat.
  task automatic count_beats(input int dest, output int beats, output int bad);
    logic [N-1:0] mask;
    mask       = '0;
    mask[dest] = 1'b1;
    beats = 0;
    bad   = 0;
    for (int c = 0; c < 20; c++) begin
      if (!m_axis_tvalid) break;
      if (m_axis_tready) beats++;
      if (m_axis_tdata !== src_word(dest) || s_axis_send_tready !== mask) bad++;
      step();
    end
  endtask

  logic [REQ_BITS-1:0] r, r2;
  int beats, bad;
  logic exp_b1, exp_b3;

  initial begin
    aresetn            = 1'b0;
    s_sq_valid         = 1'b0;
    s_sq_data          = '0;
    m_sq_ready         = 1'b1;
    m_axis_tready      = 1'b1;
    s_axis_send_tvalid = '1;
    s_axis_send_tlast  = '0;
    s_axis_send_tid    = '0;
    for (int i = 0; i < N; i++) begin
      s_axis_send_tdata[i*DB +: DB]         = src_word(i);
      s_axis_send_tkeep[i*(DB/8) +: (DB/8)] = {16{4'(i)}};
    end

    repeat (2) step();
    chk("rst_m_axis_tvalid", m_axis_tvalid, 0);
    chk("rst_s_sq_ready", s_sq_ready, 0);
    chk("rst_m_sq_valid", m_sq_valid, 0);
    chk("rst_src_tready", s_axis_send_tready, 0);
    aresetn = 1'b1;
    step();

    // dest=2 len=256: four beats from source 2
    r = mk_req(1, 3, 2, 256);
    s_sq_valid = 1'b1;
    s_sq_data  = r;
    #1;
    chk("t1_accept", s_sq_ready, 1);
    chk("t1_idle_tvalid", m_axis_tvalid, 0);
    chk("t1_msq_pre", m_sq_valid, 0);
    step();
    s_sq_valid = 1'b0;
    #1;
    chk("t1_msq_valid", m_sq_valid, 1);
    chk("t1_msq_data", m_sq_data, r);
    chk("t1_tkeep", m_axis_tkeep, {16{4'd2}});
    count_beats(2, beats, bad);
    chk("t1_beats", beats, 4);
    chk("t1_data_mask", bad, 0);
    chk("t1_idle_tready", s_axis_send_tready, 0);
    chk("t1_msq_popped", m_sq_valid, 0);

    // back-to-back: dest=1 len=64 then dest=3 len=128
    r  = mk_req(2, 4, 1, 64);
    r2 = mk_req(2, 5, 3, 128);
    s_sq_valid = 1'b1;
    s_sq_data  = r;
    #1;
    chk("t2_acc1", s_sq_ready, 1);
    step();
    s_sq_data = r2;
    #1;
    chk("t2_b1_data", m_axis_tdata, src_word(1));
    chk("t2_tready1", s_axis_send_tready, 4'b0010);
    chk("t2_acc2_on_done", s_sq_ready, 1);
    step();
    s_sq_valid = 1'b0;
    #1;
    chk("t2_b2_valid", m_axis_tvalid, 1);
    chk("t2_b2_data", m_axis_tdata, src_word(3));
    chk("t2_msq_r2", m_sq_data, r2);
    step();
    chk("t2_b3_valid", m_axis_tvalid, 1);
    chk("t2_b3_data", m_axis_tdata, src_word(3));
    step();
    chk("t2_idle", m_axis_tvalid, 0);

    // len=0 -> 1 beat, len=65 -> 2 beats
    send_req(mk_req(0, 1, 0, 0), "t3a_accept");
    count_beats(0, beats, bad);
    chk("t3a_beats", beats, 1);
    chk("t3a_data_mask", bad, 0);
    send_req(mk_req(0, 1, 3, 65), "t3b_accept");
    count_beats(3, beats, bad);
    chk("t3b_beats", beats, 2);
    chk("t3b_data_mask", bad, 0);

    // dest out of range: consumed, not forwarded, no data
    s_sq_valid = 1'b1;
    s_sq_data  = mk_req(0, 2, 5, 64);
    #1;
    chk("t4_consume", s_sq_ready, 1);
    step();
    s_sq_valid = 1'b0;
    #1;
    chk("t4_ready_drop", s_sq_ready, 0);
    chk("t4_no_fwd", m_sq_valid, 0);
    chk("t4_no_data", m_axis_tvalid, 0);
    chk("t4_no_tready", s_axis_send_tready, 0);
    send_req(mk_req(0, 2, 1, 64), "t4_next_accept");
    chk("t4_next_msq", m_sq_valid, 1);
    count_beats(1, beats, bad);
    chk("t4_next_beats", beats, 1);

    // full meta register stalls the next request but not the data
    m_sq_ready = 1'b0;
    r  = mk_req(3, 7, 0, 128);
    r2 = mk_req(3, 8, 2, 64);
    send_req(r, "t5_acc_a");
    s_sq_valid = 1'b1;
    s_sq_data  = r2;
    #1;
    chk("t5_stall1", s_sq_ready, 0);
    chk("t5_flow1", m_axis_tvalid, 1);
    chk("t5_msq_a", m_sq_data, r);
    step();
    chk("t5_stall2", s_sq_ready, 0);
    chk("t5_flow2", m_axis_tvalid, 1);
    step();
    chk("t5_idle", m_axis_tvalid, 0);
    chk("t5_stall3", s_sq_ready, 0);
    m_sq_ready = 1'b1;
    #1;
    chk("t5_release", s_sq_ready, 1);
    step();
    s_sq_valid = 1'b0;
    #1;
    chk("t5_msq_b_valid", m_sq_valid, 1);
    chk("t5_msq_b", m_sq_data, r2);
    count_beats(2, beats, bad);
    chk("t5_b_beats", beats, 1);

    // tlast handling: source tlast on beat 1 of 3
`ifdef AXIS_MUX_SQ_LAST_GEN_EN
    exp_b1 = 1'b0;
    exp_b3 = 1'b1;
`else
    exp_b1 = 1'b1;
    exp_b3 = 1'b0;
`endif
    send_req(mk_req(4, 1, 1, 192), "t6_accept");
    s_axis_send_tlast[1] = 1'b1;
    #1;
    chk("t6_last_b1", m_axis_tlast, exp_b1);
    step();
    s_axis_send_tlast[1] = 1'b0;
    #1;
    chk("t6_valid_b2", m_axis_tvalid, 1);
    chk("t6_last_b2", m_axis_tlast, 0);
    step();
    chk("t6_valid_b3", m_axis_tvalid, 1);
    chk("t6_last_b3", m_axis_tlast, exp_b3);
    step();
    chk("t6_end", m_axis_tvalid, 0);

    // reset during beat 2 of 4
    m_sq_ready = 1'b0;
    send_req(mk_req(5, 2, 3, 256), "t7_accept");
    step();
    chk("t7_pre_valid", m_axis_tvalid, 1);
    chk("t7_pre_msq", m_sq_valid, 1);
    aresetn = 1'b0;
    #1;
    chk("t7_rst_tvalid", m_axis_tvalid, 0);
    chk("t7_rst_tready", s_axis_send_tready, 0);
    chk("t7_rst_msq", m_sq_valid, 0);
    chk("t7_rst_sq_ready", s_sq_ready, 0);
    step();
    aresetn    = 1'b1;
    m_sq_ready = 1'b1;
    step();
    chk("t7_post_tvalid", m_axis_tvalid, 0);
    chk("t7_post_tready", s_axis_send_tready, 0);
    chk("t7_post_msq", m_sq_valid, 0);
    send_req(mk_req(0, 0, 2, 64), "t7_new_accept");
    count_beats(2, beats, bad);
    chk("t7_new_beats", beats, 1);
    chk("t7_new_data_mask", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
